spawn_scheduler: RTL

Sequences obstacle creation for the runner game. It sits between the game timer and `obstacle_generator` and owns three things: the difficulty schedule (target obstacle count and scroll speed versus `time_alive`), the randomized inter-spawn countdown in frames, and a req/ack handshake that tells the generator when to place a new obstacle and with which lane and sprite. It replaces the generator's ad-hoc external timer (`start_timer`/`expired_in`).

---
 rtl/spawn_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - difficulty schedule and randomized spawn req/ack sequencer
// Optional feature macro: SPAWN_LANE_GUARD_EN (no two consecutive spawns in the same lane)
module spawn_scheduler #(
  parameter int MAX_OBSTACLES = 10,
  parameter int BASE_WAIT     = 4,
  parameter int WAIT_SHIFT    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        game_reset,
  input  logic        frame_trigger,
  input  logic [11:0] time_alive,
  input  logic [3:0]  curr_active,
  input  logic [3:0]  random_num,
  input  logic [1:0]  random_lane,
  input  logic [1:0]  random_sprite,
  input  logic        spawn_ack,
  output logic        spawn_req,
  output logic [1:0]  spawn_lane,
  output logic [1:0]  spawn_sprite,
  output logic [3:0]  target_active,
  output logic [2:0]  speed,
  output logic [1:0]  state_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;

  localparam logic [3:0] MAX_Q  = 4'(MAX_OBSTACLES);
  localparam logic [7:0] BASE_Q = 8'(BASE_WAIT);

  localparam logic [9:0][11:0] THRESH = {
    12'd330, 12'd300, 12'd270, 12'd240, 12'd210,
    12'd180, 12'd150, 12'd120, 12'd60,  12'd30
  };

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] sprite_q, sprite_d;
  logic [3:0] target_q, target_d;
  logic [2:0] speed_q, speed_d;
  logic [1:0] lane_map;
  logic [1:0] lane_pick;

  always_comb begin
    target_d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (time_alive >= THRESH[i]) target_d = target_d + 4'd1;
    end
  end

  always_comb begin
    if (time_alive >= 12'd270)      speed_d = 3'd7;
    else if (time_alive >= 12'd210) speed_d = 3'd6;
    else if (time_alive >= 12'd150) speed_d = 3'd5;
    else if (time_alive >= 12'd120) speed_d = 3'd4;
    else if (time_alive >= 12'd60)  speed_d = 3'd3;
    else if (time_alive >= 12'd30)  speed_d = 3'd2;
    else                            speed_d = 3'd1;
  end

  // Only three lanes exist; the fourth random code folds onto the centre lane.
  assign lane_map = (random_lane == 2'd3) ? 2'd1 : random_lane;

`ifdef SPAWN_LANE_GUARD_EN
  logic [1:0] last_lane_q, last_lane_d;

  // last_lane resets to 3, which never matches a mapped lane.
  assign lane_pick = (lane_map == last_lane_q)
                   ? ((last_lane_q == 2'd2) ? 2'd0 : last_lane_q + 2'd1)
                   : lane_map;
`else
  assign lane_pick = lane_map;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lane_d     = lane_q;
    sprite_d   = sprite_q;
`ifdef SPAWN_LANE_GUARD_EN
    last_lane_d = last_lane_q;
`endif
    case (state_q)
      S_IDLE: begin
        if ((curr_active < target_q) && (curr_active < MAX_Q)) begin
          wait_cnt_d = BASE_Q + ({4'd0, random_num} << WAIT_SHIFT);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 8'd0) begin
          if (curr_active >= MAX_Q) begin
            state_d = S_IDLE;
          end else begin
            lane_d   = lane_pick;
            sprite_d = random_sprite;
            state_d  = S_REQ;
          end
        end else if (frame_trigger) begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      S_REQ: begin
        if (spawn_ack) begin
          state_d = S_IDLE;
`ifdef SPAWN_LANE_GUARD_EN
          last_lane_d = lane_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // game_reset shares the reset image so a restart is indistinguishable from power-up.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
      lane_q     <= 2'd0;
      sprite_q   <= 2'd0;
      target_q   <= 4'd0;
      speed_q    <= 3'd1;
`ifdef SPAWN_LANE_GUARD_EN
      last_lane_q <= 2'd3;
`endif
    end else if (game_reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
      lane_q     <= 2'd0;
      sprite_q   <= 2'd0;
      target_q   <= 4'd0;
      speed_q    <= 3'd1;
`ifdef SPAWN_LANE_GUARD_EN
      last_lane_q <= 2'd3;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lane_q     <= lane_d;
      sprite_q   <= sprite_d;
      target_q   <= target_d;
      speed_q    <= speed_d;
`ifdef SPAWN_LANE_GUARD_EN
      last_lane_q <= last_lane_d;
`endif
    end
  end

  assign spawn_req     = (state_q == S_REQ);
  assign spawn_lane    = lane_q;
  assign spawn_sprite  = sprite_q;
  assign target_active = target_q;
  assign speed         = speed_q;
  assign state_out     = state_q;

endmodule
